// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: register index and forwarding scoreboard entry.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef struct packed {
    logic     valid;
    logic     wen;
    regbits_t dest;
    logic     load;
  } fwd_entry_t;

  localparam int FWD_ENTRY_W = $bits(fwd_entry_t);

endpackage

// File: rtl/fwd_scoreboard_lookup.sv
// Per-operand bypass lookup: finds the youngest in-flight producer of one source
// register and reports whether its data is not yet forwardable.
module fwd_lookup
  import cpu_types_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int SELW       = 2
) (
  input  logic [DEPTH*FWD_ENTRY_W-1:0] i_entries,
  input  logic [4:0]                   i_src,
  output logic [SELW-1:0]              o_sel,
  output logic                         o_unready
);

  fwd_entry_t w_ent;

  // i_entries holds stages 1..DEPTH (EX excluded); scan oldest first so the
  // youngest match is the last one written.
  always_comb begin
    o_sel     = '0;
    o_unready = 1'b0;
    w_ent     = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      w_ent = fwd_entry_t'(i_entries[(k-1)*FWD_ENTRY_W +: FWD_ENTRY_W]);
      if (w_ent.valid && w_ent.wen && (w_ent.dest != '0) && (w_ent.dest == i_src)) begin
        o_sel     = SELW'(k);
        o_unready = w_ent.load && (k < LOAD_STAGE);
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding/hazard unit: shift-register scoreboard of in-flight writes from EX
// through DEPTH stages, per-source bypass selects, bubble insertion, stall counter.
module fwd_scoreboard
  import cpu_types_pkg::*;
#(
  parameter int NSRC       = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int CNTW       = 16
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic                                issue_valid,
  input  logic                                issue_wen,
  input  logic [4:0]                          issue_dest,
  input  logic                                issue_load,
  input  logic                                flush,
  input  logic                                freeze,
  input  logic [NSRC*5-1:0]                   src_reg,
  output logic [NSRC*$clog2(DEPTH+1)-1:0]     sel,
  output logic                                hazard,
  output logic [CNTW-1:0]                     stall_cnt
);

  localparam int SELW = $clog2(DEPTH+1);

  fwd_entry_t                   r_sb [DEPTH:0];
  logic [CNTW-1:0]              r_cnt;
  logic [DEPTH*FWD_ENTRY_W-1:0] w_older;
  logic [NSRC-1:0]              w_unready;

  always_comb begin
    w_older = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      w_older[(k-1)*FWD_ENTRY_W +: FWD_ENTRY_W] = r_sb[k];
    end
  end

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    fwd_lookup #(
      .DEPTH      (DEPTH),
      .LOAD_STAGE (LOAD_STAGE),
      .SELW       (SELW)
    ) u_lookup (
      .i_entries (w_older),
      .i_src     (src_reg[s*5 +: 5]),
      .o_sel     (sel[s*SELW +: SELW]),
      .o_unready (w_unready[s])
    );
  end

  assign hazard    = |w_unready;
  assign stall_cnt = r_cnt;

  // On a hazard the EX instruction holds and a bubble enters stage 1 while
  // older producers keep draining toward WB.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k <= DEPTH; k++) begin
        r_sb[k] <= '0;
      end
      r_cnt <= '0;
    end else if (!freeze) begin
      if (hazard) begin
        for (int k = DEPTH; k >= 2; k--) begin
          r_sb[k] <= r_sb[k-1];
        end
        r_sb[1] <= '0;
        if (r_cnt != {CNTW{1'b1}}) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        for (int k = DEPTH; k >= 1; k--) begin
          r_sb[k] <= r_sb[k-1];
        end
        r_sb[0] <= '{valid: issue_valid & ~flush,
                     wen:   issue_wen,
                     dest:  issue_dest,
                     load:  issue_load};
      end
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: default instance (a) and DEPTH=4/LOAD_STAGE=3/CNTW=2 instance (b),
// each checked every cycle against a stage-list model plus directed literal expectations.
module tb_fwd_scoreboard;

  logic       CLK;
  logic       RST;
  logic       v_i  [2];
  logic       we_i [2];
  logic [4:0] d_i  [2];
  logic       ld_i [2];
  logic       fl_i [2];
  logic       fz_i [2];
  logic [9:0] src_i[2];

  logic [3:0]  sel_a;
  logic        hazard_a;
  logic [15:0] cnt_a;
  logic [5:0]  sel_b;
  logic        hazard_b;
  logic [1:0]  cnt_b;

  int n_pass  = 0;
  int n_total = 0;

  fwd_scoreboard u_a (
    .CLK(CLK), .RST(RST),
    .issue_valid(v_i[0]), .issue_wen(we_i[0]), .issue_dest(d_i[0]), .issue_load(ld_i[0]),
    .flush(fl_i[0]), .freeze(fz_i[0]), .src_reg(src_i[0]),
    .sel(sel_a), .hazard(hazard_a), .stall_cnt(cnt_a)
  );

  fwd_scoreboard #(.NSRC(2), .DEPTH(4), .LOAD_STAGE(3), .CNTW(2)) u_b (
    .CLK(CLK), .RST(RST),
    .issue_valid(v_i[1]), .issue_wen(we_i[1]), .issue_dest(d_i[1]), .issue_load(ld_i[1]),
    .flush(fl_i[1]), .freeze(fz_i[1]), .src_reg(src_i[1]),
    .sel(sel_b), .hazard(hazard_b), .stall_cnt(cnt_b)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1);
  end

  // ---------------- behavioural model ----------------
  // Each instance is a list of stage slots; slot k holds whatever instruction
  // currently occupies stage k (0 = EX).
  typedef struct {
    bit       v;
    bit       w;
    bit       l;
    bit [4:0] d;
  } ent_t;

  ent_t m     [2][5];
  int   m_dep [2] = '{3, 4};
  int   m_ls  [2] = '{2, 3};
  int   m_max [2] = '{65535, 3};
  int   m_cnt [2];
  bit   exp_hz[2] = '{1'b0, 1'b0};
  bit   chk_en = 1'b0;

  function automatic void model_eval(input int i, input bit [4:0] src,
                                     output int sel, output bit unr);
    sel = 0;
    unr = 1'b0;
    for (int k = 1; k <= m_dep[i]; k++) begin
      if (m[i][k].v && m[i][k].w && m[i][k].d != 5'd0 && m[i][k].d == src) begin
        sel = k;
        unr = m[i][k].l && (k < m_ls[i]);
        break;
      end
    end
  endfunction

  always @(posedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (RST) begin
        for (int k = 0; k < 5; k++) m[i][k].v = 1'b0;
        m_cnt[i] = 0;
        chk_en   = 1'b1;
      end else if (!fz_i[i]) begin
        if (exp_hz[i]) begin
          for (int k = m_dep[i]; k >= 2; k--) m[i][k] = m[i][k-1];
          m[i][1].v = 1'b0;
          if (m_cnt[i] < m_max[i]) m_cnt[i] = m_cnt[i] + 1;
        end else begin
          for (int k = m_dep[i]; k >= 1; k--) m[i][k] = m[i][k-1];
          m[i][0].v = v_i[i] & ~fl_i[i];
          m[i][0].w = we_i[i];
          m[i][0].d = d_i[i];
          m[i][0].l = ld_i[i];
        end
      end
    end
  end

  // ---------------- compare ----------------
  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  function automatic int dut_sel(input int i, input int s);
    return (i == 0) ? int'(sel_a[s*2 +: 2]) : int'(sel_b[s*3 +: 3]);
  endfunction

  function automatic int dut_hz(input int i);
    return (i == 0) ? int'(hazard_a) : int'(hazard_b);
  endfunction

  function automatic int dut_cnt(input int i);
    return (i == 0) ? int'(cnt_a) : int'(cnt_b);
  endfunction

  int c_sel;
  bit c_unr;
  bit c_hz;

  always @(negedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      c_hz = 1'b0;
      for (int s = 0; s < 2; s++) begin
        model_eval(i, src_i[i][s*5 +: 5], c_sel, c_unr);
        c_hz = c_hz | c_unr;
        if (chk_en) chk($sformatf("model_sel inst%0d src%0d", i, s), dut_sel(i, s), c_sel);
      end
      exp_hz[i] = c_hz;
      if (chk_en) begin
        chk($sformatf("model_hazard inst%0d", i), dut_hz(i), int'(c_hz));
        chk($sformatf("model_stall_cnt inst%0d", i), dut_cnt(i), m_cnt[i]);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic idle_all();
    for (int j = 0; j < 2; j++) begin
      v_i[j] = 1'b0; we_i[j] = 1'b0; d_i[j] = 5'd0; ld_i[j] = 1'b0;
      fl_i[j] = 1'b0; fz_i[j] = 1'b0; src_i[j] = 10'd0;
    end
  endtask

  // One cycle: drive instance i (other idle) after the edge, return at the negedge.
  task automatic cyc(input int i, input logic v, input logic we, input logic [4:0] d,
                     input logic ld, input logic fl, input logic fz,
                     input logic [4:0] s0, input logic [4:0] s1);
    @(posedge CLK); #1;
    RST = 1'b0;
    idle_all();
    v_i[i] = v; we_i[i] = we; d_i[i] = d; ld_i[i] = ld;
    fl_i[i] = fl; fz_i[i] = fz; src_i[i] = {s1, s0};
    @(negedge CLK);
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    idle_all();
    RST = 1'b1;
    @(negedge CLK);
  endtask

  int hz_n;

  // ---------------- stimulus ----------------
  initial begin
    RST = 1'b1;
    idle_all();

    // 1. reset with random inputs, sources = r5
    for (int c = 0; c < 2; c++) begin
      @(posedge CLK); #1;
      RST = 1'b1;
      for (int j = 0; j < 2; j++) begin
        v_i[j]  = 1'($urandom_range(0, 1));
        we_i[j] = 1'($urandom_range(0, 1));
        d_i[j]  = 5'($urandom_range(0, 31));
        ld_i[j] = 1'($urandom_range(0, 1));
        fl_i[j] = 1'($urandom_range(0, 1));
        fz_i[j] = 1'($urandom_range(0, 1));
        src_i[j] = {5'd5, 5'd5};
      end
      @(negedge CLK);
      if (c == 1) begin
        chk("reset sel_a", int'(sel_a), 0);
        chk("reset hazard_a", int'(hazard_a), 0);
        chk("reset cnt_a", int'(cnt_a), 0);
        chk("reset sel_b", int'(sel_b), 0);
        chk("reset cnt_b", int'(cnt_b), 0);
      end
    end

    // 2. ALU chain: add r5; sub r6<-r5,r5; or r7<-r5,r6
    cyc(0, 1, 1, 5'd5, 0, 0, 0, 5'd0, 5'd0);
    cyc(0, 1, 1, 5'd6, 0, 0, 0, 5'd0, 5'd0);
    cyc(0, 1, 1, 5'd7, 0, 0, 0, 5'd5, 5'd5);
    chk("alu sub sel0", dut_sel(0, 0), 1);
    chk("alu sub sel1", dut_sel(0, 1), 1);
    chk("alu sub hazard", int'(hazard_a), 0);
    cyc(0, 0, 0, 5'd0, 0, 0, 0, 5'd5, 5'd6);
    chk("alu or sel0", dut_sel(0, 0), 2);
    chk("alu or sel1", dut_sel(0, 1), 1);
    chk("alu or hazard", int'(hazard_a), 0);

    // 3. load-use: lw r8; add r9<-r8,r0
    do_reset();
    cyc(0, 1, 1, 5'd8, 1, 0, 0, 5'd0, 5'd0);
    cyc(0, 1, 1, 5'd9, 0, 0, 0, 5'd0, 5'd0);
    cyc(0, 0, 0, 5'd0, 0, 0, 0, 5'd8, 5'd0);
    chk("lu hazard onset", int'(hazard_a), 1);
    chk("lu sel0 onset", dut_sel(0, 0), 1);
    cyc(0, 0, 0, 5'd0, 0, 0, 0, 5'd8, 5'd0);
    chk("lu hazard release", int'(hazard_a), 0);
    chk("lu sel0 release", dut_sel(0, 0), 2);
    chk("lu sel1 release", dut_sel(0, 1), 0);
    chk("lu stall_cnt", int'(cnt_a), 1);

    // 4. r0 and wen guards
    do_reset();
    cyc(0, 1, 1, 5'd0, 0, 0, 0, 5'd0, 5'd0);
    cyc(0, 1, 0, 5'd3, 0, 0, 0, 5'd0, 5'd0);
    cyc(0, 1, 1, 5'd4, 0, 0, 0, 5'd0, 5'd0);
    cyc(0, 0, 0, 5'd0, 0, 0, 0, 5'd0, 5'd3);
    chk("guard r0 sel0", dut_sel(0, 0), 0);
    chk("guard wen sel1", dut_sel(0, 1), 0);

    // 5. freeze 4 cycles at hazard onset
    do_reset();
    cyc(0, 1, 1, 5'd8, 1, 0, 0, 5'd0, 5'd0);
    cyc(0, 1, 1, 5'd9, 0, 0, 0, 5'd0, 5'd0);
    hz_n = 0;
    for (int f = 0; f < 4; f++) begin
      cyc(0, 0, 0, 5'd0, 0, 0, 1, 5'd8, 5'd0);
      hz_n += int'(hazard_a);
    end
    chk("frz cnt held", int'(cnt_a), 0);
    for (int t = 0; t < 8; t++) begin
      cyc(0, 0, 0, 5'd0, 0, 0, 0, 5'd8, 5'd0);
      if (!hazard_a) break;
      hz_n++;
    end
    chk("frz hazard cycles", hz_n, 5);
    chk("frz sel0 release", dut_sel(0, 0), 2);
    chk("frz stall_cnt", int'(cnt_a), 1);

    // older ready producer must not mask a younger unready load
    do_reset();
    cyc(0, 1, 1, 5'd8, 0, 0, 0, 5'd0, 5'd0);
    cyc(0, 1, 1, 5'd8, 1, 0, 0, 5'd0, 5'd0);
    cyc(0, 1, 1, 5'd9, 0, 0, 0, 5'd0, 5'd0);
    cyc(0, 0, 0, 5'd0, 0, 0, 0, 5'd8, 5'd8);
    chk("mask hazard", int'(hazard_a), 1);
    chk("mask sel1", dut_sel(0, 1), 1);
    cyc(0, 0, 0, 5'd0, 0, 0, 0, 5'd8, 5'd8);
    chk("mask release sel0", dut_sel(0, 0), 2);

    // 6. DEPTH=4 LOAD_STAGE=3 CNTW=2: back-to-back lw/use pairs, counter saturates
    do_reset();
    for (int p = 0; p < 3; p++) begin
      cyc(1, 1, 1, 5'(10 + p), 1, 0, 0, 5'd0, 5'd0);
      cyc(1, 1, 1, 5'd20, 0, 0, 0, 5'd0, 5'd0);
      hz_n = 0;
      for (int t = 0; t < 8; t++) begin
        cyc(1, 0, 0, 5'd0, 0, 0, 0, 5'(10 + p), 5'd0);
        if (!hazard_b) break;
        hz_n++;
      end
      chk($sformatf("p6 pair%0d stall cycles", p), hz_n, 2);
      chk($sformatf("p6 pair%0d sel0", p), dut_sel(1, 0), 3);
      chk($sformatf("p6 pair%0d stall_cnt", p), int'(cnt_b), (p == 0) ? 2 : 3);
    end

    // flushed lw leaves nothing for its consumer
    cyc(1, 1, 1, 5'd12, 1, 1, 0, 5'd0, 5'd0);
    cyc(1, 1, 1, 5'd21, 0, 0, 0, 5'd0, 5'd0);
    cyc(1, 0, 0, 5'd0, 0, 0, 0, 5'd12, 5'd0);
    chk("flush hazard", int'(hazard_b), 0);
    chk("flush sel0", dut_sel(1, 0), 0);
    chk("flush cnt hold", int'(cnt_b), 3);

    cyc(0, 0, 0, 5'd0, 0, 0, 0, 5'd0, 5'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
